writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-low reset; 0 clears all state.
REQ-004 mem_valid  in  1  MEM/WB stage presents a retiring instruction.
REQ-005 mem_ready  out  1  block can accept the offered instruction this cycle.
REQ-006 mem_reg_write  in  1  retiring instruction writes a register.
REQ-007 mem_to_reg  in  1  select source: 1 = mem_data_out, 0 = alu_data_out.
REQ-008 mem_rd  in  5  destination register address.
REQ-009 alu_data_out  in  32  ALU result.
REQ-010 mem_data_out  in  32  load data.
REQ-011 rf_wr_grant  in  1  register-file write port available this cycle.
REQ-012 reg_write  out  1  register-file write strobe; also clears the decoder scoreboard flag.
REQ-013 reg_wr_addr_wb  out  5  write address.
REQ-014 reg_wr_data  out  32  write data.
REQ-015 fwd_valid  out  1  head entry is valid for forwarding.
REQ-016 fwd_addr  out  5  head entry address.
REQ-017 fwd_data  out  32  head entry data.
REQ-018 retire_count  out  16  count of completed register writes.

Function
REQ-019 Retire buffer: 2-entry FIFO. Each entry holds {addr[4:0], data[31:0]}. Occupancy states are EMPTY, ONE and FULL.
REQ-020 mem_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL. It depends on registered state only.
REQ-021 Accept condition: mem_valid & mem_ready at the rising edge.
  - mem_reg_write=1: enqueue {mem_rd, mem_to_reg ? mem_data_out : alu_data_out}.
  - mem_reg_write=0: consume the instruction, no enqueue, no counter change.
REQ-022 Issue: reg_write = head_valid & rf_wr_grant (combinational). reg_wr_addr_wb and reg_wr_data come from the head entry. The entry dequeues at that edge.
REQ-023 When reg_write=0, reg_wr_addr_wb and reg_wr_data SHALL be 0.
REQ-024 Latency: an instruction accepted at edge N SHALL produce reg_write in cycle N+1 at the earliest, if it is at the head and granted. There is no combinational path from mem_* to reg_write.
REQ-025 Order: writes SHALL leave in acceptance order. There is no coalescing, even for the same address.
REQ-026 rd=0 with mem_reg_write=1 SHALL be enqueued and issued normally, so its scoreboard flag clears. The register file discards the data.
REQ-027 Simultaneous enqueue and dequeue in ONE: occupancy stays ONE and the new entry becomes head.
REQ-028 Simultaneous enqueue and dequeue in EMPTY is impossible.
REQ-029 In FULL, no enqueue occurs. A dequeue in FULL goes to ONE; mem_ready rises the next cycle.
REQ-030 Transitions:
  - EMPTY -> ONE on enqueue.
  - ONE -> FULL on enqueue without dequeue.
  - ONE -> EMPTY on dequeue without enqueue.
  - FULL -> ONE on dequeue.
  - Otherwise the state holds.
REQ-031 rf_wr_grant=0 for any number of cycles SHALL hold the buffer contents unchanged.
REQ-032 Forwarding: fwd_valid = head_valid. fwd_addr and fwd_data equal the head entry; they are 0 when empty.
REQ-033 retire_count increments by 1 on each cycle with reg_write=1. It wraps from 0xFFFF to 0x0000.
REQ-034 Held inputs: mem_* held while mem_ready=0 SHALL NOT be accepted twice.

Reset
REQ-035 reset=0 SHALL immediately force state EMPTY and drive these outputs to 0: reg_write, reg_wr_addr_wb, reg_wr_data, fwd_*, retire_count.
REQ-036 After reset release, mem_ready SHALL be 1 from the first cycle.
REQ-037 Reset mid-operation SHALL discard all buffered entries without issuing writes.

Structure
REQ-038 A shared package cpu_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, WB_DEPTH=2 and the occupancy-state enumeration.
REQ-039 The FIFO storage and pointers SHALL be one sub-module, wb_fifo. The source mux, issue logic and counter stay in writeback_unit.

Verification
REQ-040 Single ALU op: reset release, rf_wr_grant=1, accept rd=5, mem_to_reg=0, alu=0x1234 -> next cycle reg_write=1, addr=5, data=0x00001234, retire_count=1.
REQ-041 Load select: rd=7, mem_to_reg=1, mem=0xDEADBEEF, alu=0x1 -> written data 0xDEADBEEF.
REQ-042 Backpressure: rf_wr_grant=0, offer 3 writes (rd=1,2,3) -> first two accepted, mem_ready=0. Then grant=1 -> writes 1,2 in order, then 3 accepted and written; retire_count=3.
REQ-043 Non-writing instruction: mem_reg_write=1 rd=0 then mem_reg_write=0 -> one write to addr 0, no write for the second, retire_count=1.
REQ-044 Wrap: preload retire_count to 0xFFFF via 65535 writes, one more -> retire_count=0x0000.
REQ-045 Reset mid-op: FULL with grant=0, assert reset -> all outputs 0 immediately. After release, no reg_write occurs without new input.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the write-back stage.
//   REG_ADDR_W  : register address width
//   DATA_W      : register data width
//   WB_DEPTH    : number of retire-buffer entries
//   CNT_W       : width of the retire counter
//   wb_occ_e    : retire-buffer occupancy state (EMPTY / ONE / FULL)
//   wb_entry_t  : one buffered register write {addr, data}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int WB_DEPTH   = 2;
    localparam int CNT_W      = 16;
    localparam int WB_PTR_W   = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } wb_occ_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Circular pointer advance for a buffer of WB_DEPTH entries.
    function automatic logic [WB_PTR_W-1:0] wb_ptr_inc(input logic [WB_PTR_W-1:0] ptr);
        if (ptr == WB_PTR_W'(WB_DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Retire buffer: a WB_DEPTH (2) entry FIFO of pending register writes with an
// explicit EMPTY / ONE / FULL occupancy state machine.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset, clears pointers/occupancy/data
//   enq        in   push {enq_addr, enq_data} this edge (ignored when FULL)
//   enq_addr   in   address of the pushed entry
//   enq_data   in   data of the pushed entry
//   deq        in   pop the head entry this edge (ignored when EMPTY)
//   head_valid out  buffer holds at least one entry
//   head_addr  out  head entry address, 0 when empty
//   head_data  out  head entry data, 0 when empty
//   not_full   out  buffer can take a new entry (from registered state only)
// -----------------------------------------------------------------------------
module wb_fifo
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq,
    input  logic [REG_ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0]     enq_data,
    input  logic                  deq,
    output logic                  head_valid,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic                  not_full
);

    wb_occ_e               occ_q, occ_d;
    logic [WB_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WB_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    wb_entry_t             mem_q [WB_DEPTH];
    wb_entry_t             mem_d [WB_DEPTH];

    logic                  enq_ok;
    logic                  deq_ok;
    wb_entry_t             head_entry;

    // Qualify requests against the current occupancy so a stray request can
    // never corrupt the pointers.
    assign enq_ok = enq & (occ_q != OCC_FULL);
    assign deq_ok = deq & (occ_q != OCC_EMPTY);

    // Storage next-state: only the slot under the write pointer can change.
    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (enq_ok && (wr_ptr_q == WB_PTR_W'(gi))) begin
                    mem_d[gi].addr = enq_addr;
                    mem_d[gi].data = enq_data;
                end
            end
        end
    endgenerate

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (enq_ok) begin
            wr_ptr_d = wb_ptr_inc(wr_ptr_q);
        end
        if (deq_ok) begin
            rd_ptr_d = wb_ptr_inc(rd_ptr_q);
        end

        unique case (occ_q)
            OCC_EMPTY: begin
                if (enq_ok) begin
                    occ_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // Push and pop together keep one entry; the new one is head.
                if (enq_ok && !deq_ok) begin
                    occ_d = OCC_FULL;
                end else if (deq_ok && !enq_ok) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (deq_ok) begin
                    occ_d = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < WB_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign head_valid = (occ_q != OCC_EMPTY);
    assign head_addr  = head_valid ? head_entry.addr : '0;
    assign head_data  = head_valid ? head_entry.data : '0;
    assign not_full   = (occ_q != OCC_FULL);

endmodule

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Write-back stage: accepts retiring instructions from MEM/WB, buffers their
// register writes in a 2-entry retire buffer and issues them to the register
// file when its write port is granted. The head entry is also exposed for
// forwarding, and completed writes are counted.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   mem_valid       in   MEM/WB offers a retiring instruction
//   mem_ready       out  offer can be accepted this cycle (registered state)
//   mem_reg_write   in   instruction writes a register
//   mem_to_reg      in   1 = write load data, 0 = write ALU result
//   mem_rd          in   destination register
//   alu_data_out    in   ALU result
//   mem_data_out    in   load data
//   rf_wr_grant     in   register-file write port free this cycle
//   reg_write       out  register-file write strobe
//   reg_wr_addr_wb  out  write address (0 when no write)
//   reg_wr_data     out  write data (0 when no write)
//   fwd_valid       out  head entry valid for forwarding
//   fwd_addr        out  head entry address
//   fwd_data        out  head entry data
//   retire_count    out  wrapping count of completed register writes
// -----------------------------------------------------------------------------
module writeback_unit
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_reg_write,
    input  logic                  mem_to_reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     alu_data_out,
    input  logic [DATA_W-1:0]     mem_data_out,
    input  logic                  rf_wr_grant,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] reg_wr_addr_wb,
    output logic [DATA_W-1:0]     reg_wr_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retire_count
);

    logic                  accept;
    logic                  enq;
    logic [DATA_W-1:0]     wb_src_data;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  not_full;
    logic [CNT_W-1:0]      retire_count_q, retire_count_d;

    // mem_ready comes straight from the buffer's registered occupancy, so the
    // handshake never loops through mem_valid.
    assign mem_ready = not_full;
    assign accept    = mem_valid & mem_ready;

    // Non-writing instructions are consumed by the handshake but never enter
    // the buffer. rd=0 writes are buffered like any other so the decoder's
    // scoreboard flag for them still clears.
    assign enq         = accept & mem_reg_write;
    assign wb_src_data = mem_to_reg ? mem_data_out : alu_data_out;

    wb_fifo u_wb_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq        (enq),
        .enq_addr   (mem_rd),
        .enq_data   (wb_src_data),
        .deq        (reg_write),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .not_full   (not_full)
    );

    // Issue depends only on buffered state and the grant: a new instruction
    // reaches reg_write no earlier than the cycle after it is accepted.
    assign reg_write      = head_valid & rf_wr_grant;
    assign reg_wr_addr_wb = reg_write ? head_addr : '0;
    assign reg_wr_data    = reg_write ? head_data : '0;

    // head_addr/head_data are already zero when the buffer is empty.
    assign fwd_valid = head_valid;
    assign fwd_addr  = head_addr;
    assign fwd_data  = head_data;

    always_comb begin
        retire_count_d = retire_count_q;
        if (reg_write) begin
            retire_count_d = retire_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
// Scoreboard bench: the driver pushes every accepted register write into a
// queue that stands for the retire buffer contents; the monitor compares the
// DUT's handshake, forwarding and issue outputs against that queue each cycle
// and pops an entry whenever a write is expected to leave.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] alu_data_out = '0;
    logic [31:0] mem_data_out = '0;
    logic        rf_wr_grant = 1'b0;
    logic        reg_write;
    logic [4:0]  reg_wr_addr_wb;
    logic [31:0] reg_wr_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [15:0] retire_count;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    int   occ_before = 0;

    writeback_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_rd         (mem_rd),
        .alu_data_out   (alu_data_out),
        .mem_data_out   (mem_data_out),
        .rf_wr_grant    (rf_wr_grant),
        .reg_write      (reg_write),
        .reg_wr_addr_wb (reg_wr_addr_wb),
        .reg_wr_data    (reg_wr_data),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .retire_count   (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30) begin
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
            end
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion (t=%0t)", nm, $time);
    endtask

    // Monitor: samples in the low phase, 2 time units after the falling edge.
    always begin
        exp_t h;
        bit   hv;
        bit   exp_wr;
        @(negedge clk);
        #2;
        occ_before = exp_q.size();
        if (reset === 1'b1) begin
            hv = (exp_q.size() > 0);
            if (hv) begin
                h = exp_q[0];
            end else begin
                h.addr = '0;
                h.data = '0;
            end
            exp_wr = hv && (rf_wr_grant === 1'b1);
            check("mem_ready", {31'd0, mem_ready}, {31'd0, (exp_q.size() < 2)});
            check("fwd_valid", {31'd0, fwd_valid}, {31'd0, hv});
            check("fwd_addr", {27'd0, fwd_addr}, {27'd0, h.addr});
            check("fwd_data", fwd_data, h.data);
            check("retire_count", {16'd0, retire_count}, model_cnt & 32'hFFFF);
            check("reg_write", {31'd0, reg_write}, {31'd0, exp_wr});
            if (exp_wr) begin
                check("wr_addr", {27'd0, reg_wr_addr_wb}, {27'd0, h.addr});
                check("wr_data", reg_wr_data, h.data);
                void'(exp_q.pop_front());
                model_cnt++;
            end else begin
                check("wr_addr_idle", {27'd0, reg_wr_addr_wb}, 32'd0);
                check("wr_data_idle", reg_wr_data, 32'd0);
            end
        end
    end

    // One stimulus cycle; acceptance follows from the model occupancy.
    task automatic cyc(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic g,
                       output bit acc);
        exp_t e;
        @(negedge clk);
        mem_valid     = v;
        mem_reg_write = rw;
        mem_to_reg    = m2r;
        mem_rd        = rd;
        alu_data_out  = alu;
        mem_data_out  = mem;
        rf_wr_grant   = g;
        #3;
        acc = v && (occ_before < 2);
        if (acc && rw) begin
            e.addr = rd;
            e.data = m2r ? mem : alu;
            exp_q.push_back(e);
        end
    endtask

    // Hold an offer until it is accepted.
    task automatic offer(input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic g);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            cyc(1'b1, rw, m2r, rd, alu, mem, g, acc);
        end
        if (!acc) begin
            timeout_fail("offer_timeout");
        end
    endtask

    task automatic idle(input int n, input logic g);
        bit acc;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, g, acc);
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 20) begin
            idle(1, 1'b1);
            i++;
        end
        idle(1, 1'b1);
        if (exp_q.size() > 0) begin
            timeout_fail("drain_timeout");
        end
    endtask

    // Asynchronous reset in the low phase; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        mem_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_wr_addr", {27'd0, reg_wr_addr_wb}, 32'd0);
        check("rst_wr_data", reg_wr_data, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_fwd_addr", {27'd0, fwd_addr}, 32'd0);
        check("rst_fwd_data", fwd_data, 32'd0);
        check("rst_retire_count", {16'd0, retire_count}, 32'd0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        bit acc;

        // Single ALU op.
        do_reset();
        offer(1'b1, 1'b0, 5'd5, 32'h1234, 32'hAAAA_AAAA, 1'b1);
        @(negedge clk);
        mem_valid = 1'b0;
        rf_wr_grant = 1'b1;
        #1;
        check("alu_reg_write", {31'd0, reg_write}, 32'd1);
        check("alu_addr", {27'd0, reg_wr_addr_wb}, 32'd5);
        check("alu_data", reg_wr_data, 32'h0000_1234);
        @(negedge clk);
        #1;
        check("alu_retire_count", {16'd0, retire_count}, 32'd1);

        // Load select.
        do_reset();
        offer(1'b1, 1'b1, 5'd7, 32'h1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        mem_valid = 1'b0;
        rf_wr_grant = 1'b1;
        #1;
        check("load_addr", {27'd0, reg_wr_addr_wb}, 32'd7);
        check("load_data", reg_wr_data, 32'hDEAD_BEEF);
        drain();

        // Backpressure.
        do_reset();
        offer(1'b1, 1'b0, 5'd1, 32'h11, 32'h0, 1'b0);
        offer(1'b1, 1'b0, 5'd2, 32'h22, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h0, 1'b0, acc);
        check("bp_mem_ready", {31'd0, mem_ready}, 32'd0);
        idle(3, 1'b0);
        check("bp_hold_fwd_addr", {27'd0, fwd_addr}, 32'd1);
        offer(1'b1, 1'b0, 5'd3, 32'h33, 32'h0, 1'b1);
        drain();
        check("bp_retire_count", {16'd0, retire_count}, 32'd3);

        // Non-writing instruction and rd=0.
        do_reset();
        offer(1'b1, 1'b0, 5'd0, 32'h55, 32'h0, 1'b1);
        offer(1'b0, 1'b0, 5'd9, 32'h66, 32'h0, 1'b1);
        drain();
        check("nowr_retire_count", {16'd0, retire_count}, 32'd1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 80),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, ($urandom_range(0, 99) < 65), acc);
        end
        drain();

        // Counter wrap: 65536 writes bring the count back to zero.
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, 1'b1, acc);
        end
        idle(1, 1'b0);
        check("wrap_before_last", {16'd0, retire_count}, 32'h0000_FFFF);
        drain();
        check("wrap_retire_count", {16'd0, retire_count}, 32'd0);

        // Reset in the middle of operation with a full buffer.
        do_reset();
        offer(1'b1, 1'b0, 5'd10, 32'hA, 32'h0, 1'b0);
        offer(1'b1, 1'b0, 5'd11, 32'hB, 32'h0, 1'b0);
        idle(1, 1'b0);
        check("midop_full", {31'd0, mem_ready}, 32'd0);
        do_reset();
        idle(6, 1'b1);
        check("midop_no_write_count", {16'd0, retire_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
